if_prefetch_queue: RTL

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction prefetch queue between instruction memory and IF/ID.
// Keeps at most one fetch outstanding and buffers up to DEPTH returned
// instructions tagged with their fetch address. Redirect flushes the queue and
// marks any in-flight fetch stale so that its response is dropped.
// Optional feature macro: PREFETCH_BYPASS_EN (same-cycle response forwarding
// when the queue is empty).
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [63:0]              imem_adr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    input  logic                     hold,
    output logic                     out_valid,
    output logic [31:0]              instr_out,
    output logic [63:0]              pc_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_adr_q,  req_adr_d;
    logic          pending_q,  pending_d;
    logic          stale_q,    stale_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [63:0]   mem_adr_q  [DEPTH];
    logic [63:0]   mem_adr_d  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];

    logic          resp_live;
    logic          head_valid;
    logic          bypass;
    logic          pop;
    logic          q_pop;
    logic          push;
    logic [CW:0]   reserved;

    // A response belongs to us only if a request is pending and not flushed.
    assign resp_live  = imem_valid && pending_q && !stale_q;
    assign head_valid = (count_q != '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = resp_live && !head_valid && !redirect && !rst;
`else
    assign bypass = 1'b0;
`endif

    // Head-of-queue (or forwarded response) presented toward IF/ID.
    always_comb begin
        out_valid = 1'b0;
        instr_out = NOP;
        pc_out    = '0;
        if (head_valid) begin
            out_valid = 1'b1;
            instr_out = mem_data_q[rd_ptr_q];
            pc_out    = mem_adr_q[rd_ptr_q];
        end else if (bypass) begin
            out_valid = 1'b1;
            instr_out = imem_data;
            pc_out    = req_adr_q;
        end
    end

    assign pop   = out_valid && !hold;
    assign q_pop = pop && head_valid;
    // A forwarded response that is consumed this cycle never enters the queue.
    assign push  = resp_live && !(bypass && !hold);

    // Slots committed after this cycle: stored entries plus the live in-flight
    // fetch, less the entry leaving now. A new fetch needs one more free slot.
    assign reserved = {1'b0, count_q}
                    + (CW + 1)'(pending_q && !stale_q)
                    - (CW + 1)'(pop);

    // Fetch request issue.
    always_comb begin
        imem_req = !rst && !redirect && (!pending_q || imem_valid)
                   && (reserved < DEPTH_W);
        imem_adr = fetch_pc_q;
    end

    assign count = count_q;

    // Next-state: fetch PC, outstanding-request tracking and queue pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_adr_d  = req_adr_q;
        pending_d  = pending_q;
        stale_d    = stale_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_adr_d  = mem_adr_q;
        mem_data_d = mem_data_q;

        if (imem_valid && pending_q) begin
            pending_d = 1'b0;
            stale_d   = 1'b0;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Only a fetch still in flight after this edge needs to be dropped.
            stale_d    = pending_q && !imem_valid;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + 64'h4;
                req_adr_d  = fetch_pc_q;
                pending_d  = 1'b1;
            end
            if (push) begin
                mem_adr_d[wr_ptr_q]  = req_adr_q;
                mem_data_d[wr_ptr_q] = imem_data;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(q_pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_adr_q  <= '0;
            pending_q  <= 1'b0;
            stale_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_adr_q  <= req_adr_d;
            pending_q  <= pending_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_adr_q  <= mem_adr_d;
        mem_data_q <= mem_data_d;
    end

endmodule
